// File: rtl/adc_cas_pkg.sv
// Shared constants and FSM state codes for the ADC cassette slicer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_cas_pkg;

    // Default build parameters
    localparam int DEF_SAMPLE_W     = 12;
    localparam int DEF_DEPTH_LOG2   = 9;
    localparam int DEF_HYST         = 100;
    localparam int DEF_IDLE_TIMEOUT = 4800;

    // Per-sample sequencer states
    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_RD    = 3'd2;
    localparam logic [2:0] ST_ACC   = 3'd3;
    localparam logic [2:0] ST_CMP   = 3'd4;

endpackage

// File: rtl/adc_ring_ram.sv
// Ring buffer holding the averaging window: one write port, one registered read port.
// Latency: read data appears the cycle after rd_en; writes land on the clock edge.
// Backpressure: none; the caller never reads and writes in the same cycle.
module adc_ring_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    // No reset on the array so it maps onto block RAM; the owner clears it explicitly.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_cassette_slicer.sv
// Slices LTC2308 samples into the cassette bit against a running window average, with hysteresis.
// Latency: event seen in cycle E, cas_bit/avg/sample_stb visible after the edge ending cycle E+3.
// Backpressure: none; a sample arriving while one is in flight is dropped and flagged in overrun.
module adc_cassette_slicer
    import adc_cas_pkg::*;
#(
    parameter int SAMPLE_W     = DEF_SAMPLE_W,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int HYST         = DEF_HYST,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_sync,
    input  logic                polarity,
    output logic                cas_bit,
    output logic                sample_stb,
    output logic [SAMPLE_W-1:0] avg,
    output logic                carrier,
    output logic                overrun
);

    localparam int SUM_W  = SAMPLE_W + DEPTH_LOG2;
    localparam int CMP_W  = SAMPLE_W + 2;
    localparam int FILL_W = DEPTH_LOG2 + 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [FILL_W-1:0]       FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [IDLE_W-1:0]       IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
    localparam logic signed [CMP_W-1:0] HYST_C   = CMP_W'(HYST);
    localparam logic [DEPTH_LOG2-1:0]   PTR_LAST = '1;
    localparam logic [DEPTH_LOG2-1:0]   PTR_ONE  = DEPTH_LOG2'(1);

    logic [2:0]            state_q;
    logic                  adc_sync_d;
    logic                  evt;
    logic [SAMPLE_W-1:0]   samp_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]      sum_q;
    logic [SAMPLE_W-1:0]   avg_q;
    logic                  bit_q;
    logic                  stb_q;
    logic [FILL_W-1:0]     fill_cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  overrun_q;

    logic                  ram_wr_en;
    logic [SAMPLE_W-1:0]   ram_wr_dat;
    logic                  ram_rd_en;
    logic [SAMPLE_W-1:0]   ram_rd_dat;

    logic [SAMPLE_W-1:0]   avg_new;
    logic signed [CMP_W-1:0] samp_sx;
    logic signed [CMP_W-1:0] avg_sx;
    logic signed [CMP_W-1:0] thr_lo;
    logic signed [CMP_W-1:0] thr_hi;
    logic                  bit_new;

    // The ADC flips adc_sync once per conversion; either edge is a new sample.
    assign evt = adc_sync ^ adc_sync_d;

    // CLEAR zeroes the window; ACC overwrites the oldest entry with the new sample.
    assign ram_wr_en  = (state_q == ST_CLEAR) || (state_q == ST_ACC);
    assign ram_wr_dat = (state_q == ST_CLEAR) ? '0 : samp_q;
    assign ram_rd_en  = (state_q == ST_IDLE) && evt;

    adc_ring_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (SAMPLE_W)
    ) u_ring (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr),
        .wr_dat  (ram_wr_dat),
        .rd_en   (ram_rd_en),
        .rd_addr (wr_ptr),
        .rd_dat  (ram_rd_dat)
    );

    // Two extra sign bits keep avg-HYST below zero and avg+HYST above full scale from wrapping.
    assign avg_new = sum_q[SUM_W-1:DEPTH_LOG2];
    assign samp_sx = {2'b00, samp_q};
    assign avg_sx  = {2'b00, avg_new};
    assign thr_lo  = avg_sx - HYST_C;
    assign thr_hi  = avg_sx + HYST_C;

    // Hysteresis slicer; low samples give 1 because the CoCo cassette input is inverted.
    always_comb begin
        bit_new = bit_q;
        if (samp_sx < thr_lo) begin
            bit_new = 1'b1;
        end else if (samp_sx > thr_hi) begin
            bit_new = 1'b0;
        end
    end

    // Delay adc_sync by one cycle for toggle detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adc_sync_d <= 1'b0;
        end else begin
            adc_sync_d <= adc_sync;
        end
    end

    // Per-sample sequencer: clear window, read oldest, update running sum, slice
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_CLEAR;
            samp_q   <= '0;
            wr_ptr   <= '0;
            sum_q    <= '0;
            avg_q    <= '0;
            bit_q    <= 1'b0;
            stb_q    <= 1'b0;
            fill_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    if (wr_ptr == PTR_LAST) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (evt) begin
                        samp_q  <= adc_data;
                        state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    state_q <= ST_ACC;
                end
                ST_ACC: begin
                    sum_q  <= sum_q - {{DEPTH_LOG2{1'b0}}, ram_rd_dat}
                                    + {{DEPTH_LOG2{1'b0}}, samp_q};
                    wr_ptr <= wr_ptr + PTR_ONE;
                    if (fill_cnt != FILL_MAX) begin
                        fill_cnt <= fill_cnt + FILL_W'(1);
                    end
                    state_q <= ST_CMP;
                end
                ST_CMP: begin
                    avg_q <= avg_new;
                    bit_q <= bit_new;
                    stb_q <= 1'b1;
                    if (bit_new != bit_q) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    // Sticky flag for samples that arrive while one is still being processed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (evt && ((state_q == ST_RD) || (state_q == ST_ACC) || (state_q == ST_CMP))) begin
            overrun_q <= 1'b1;
        end
    end

    assign cas_bit    = bit_q ^ polarity;
    assign sample_stb = stb_q;
    assign avg        = avg_q;
    assign carrier    = (fill_cnt == FILL_MAX) && (idle_cnt < IDLE_MAX);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_cassette_slicer.sv
module tb_adc_cassette_slicer;
    import adc_cas_pkg::*;

    localparam int NWIN = 512;
    localparam int HY   = 100;
    localparam int TMO  = 4800;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_sync = 1'b0;
    logic        polarity = 1'b0;
    logic        cas_bit;
    logic        sample_stb;
    logic [11:0] avg;
    logic        carrier;
    logic        overrun;

    always #5 clk = ~clk;

    adc_cassette_slicer dut (
        .clk        (clk),
        .reset      (reset),
        .adc_data   (adc_data),
        .adc_sync   (adc_sync),
        .polarity   (polarity),
        .cas_bit    (cas_bit),
        .sample_stb (sample_stb),
        .avg        (avg),
        .carrier    (carrier),
        .overrun    (overrun)
    );

    typedef struct {
        int e_avg;
        int e_bit;
        int e_car;
        int e_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: a literal window of the last NWIN samples
    int win[$];
    int m_bit;
    int m_since;
    int m_count;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int win_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic model_reset();
        win.delete();
        for (int i = 0; i < NWIN; i++) win.push_back(0);
        m_bit   = 0;
        m_since = 0;
        m_count = 0;
    endtask

    task automatic model_push(input int v);
        exp_t e;
        int   a;
        int   nb;
        void'(win.pop_front());
        win.push_back(v);
        a  = win_sum() / NWIN;
        nb = m_bit;
        if (v < a - HY)      nb = 1;
        else if (v > a + HY) nb = 0;
        if (nb != m_bit) m_since = 0;
        else if (m_since < TMO) m_since++;
        m_bit = nb;
        if (m_count < NWIN) m_count++;
        e.e_avg = a;
        e.e_bit = m_bit ^ int'(polarity);
        e.e_car = (m_count >= NWIN && m_since < TMO) ? 1 : 0;
        e.e_cyc = cyc + 4;
        exp_q.push_back(e);
    endtask

    // Toggle adc_sync with a new sample, then hold off gap-1 further edges
    task automatic send(input int v, input int gap);
        @(posedge clk);
        #1;
        adc_data = 12'(v);
        adc_sync = ~adc_sync;
        model_push(v);
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic send_rnd_gap(input int v);
        send(v, int'($urandom_range(8, 4)));
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        chk(nm, exp_q.size(), 0);
    endtask

    // Monitor: every strobe pops one expectation and checks it
    always @(negedge clk) begin
        if (reset && sample_stb) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_stb", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("avg", avg, e.e_avg);
                chk("cas_bit", cas_bit, e.e_bit);
                chk("carrier", carrier, e.e_car);
                chk("stb_latency_cycle", cyc, e.e_cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cas_bit", cas_bit, 0);
        chk("rst_stb", sample_stb, 0);
        chk("rst_avg", avg, 0);
        chk("rst_carrier", carrier, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_state", dut.state_q, ST_CLEAR);

        // Window clear: a toggle at cycle 100 is ignored, IDLE after 512 edges
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        adc_data = 12'd3000;
        adc_sync = ~adc_sync;
        repeat (411) @(posedge clk);
        #1;
        chk("clear_state_511", dut.state_q, ST_CLEAR);
        @(posedge clk);
        #1;
        chk("clear_state_512", dut.state_q, ST_IDLE);
        repeat (5) @(posedge clk);
        chk("clear_overrun", overrun, 0);

        // Fill the window with mid-scale
        for (int i = 0; i < NWIN; i++) send_rnd_gap(2048);
        drain("drain_fill");
        chk("fill_avg", avg, 2048);
        chk("fill_bit", cas_bit, 0);

        // Square wave, first normal then inverted polarity
        for (int p = 0; p < 2; p++) begin
            polarity = p[0];
            for (int per = 0; per < 4; per++) begin
                for (int k = 0; k < 8; k++) send_rnd_gap(1748);
                for (int k = 0; k < 8; k++) send_rnd_gap(2348);
            end
            drain("drain_square");
        end
        polarity = 1'b0;
        chk("square_carrier", carrier, 1);

        // Constant input until carrier times out
        for (int i = 0; i < TMO; i++) send(2048, 4);
        drain("drain_idle");
        chk("idle_carrier", carrier, 0);

        // Random samples at random spacing
        for (int i = 0; i < 400; i++) send_rnd_gap(int'($urandom_range(4095, 0)));
        drain("drain_random");

        // Low boundary: avg 50, force bit 0, then sample 0 must hold
        for (int i = 0; i < NWIN; i++) send(50, 4);
        send(200, 4);
        send(0, 4);
        drain("drain_low");
        chk("low_hold_bit", cas_bit, 0);

        // High boundary: avg 4050, force bit 1, then 4095 must hold
        for (int i = 0; i < NWIN; i++) send(4050, 4);
        send(3900, 4);
        send(4095, 4);
        drain("drain_high");
        chk("high_hold_bit", cas_bit, 1);

        // Overrun: second toggle two cycles after the first is dropped
        chk("pre_overrun", overrun, 0);
        send(1000, 2);
        @(posedge clk);
        #1;
        adc_data = 12'd4000;
        adc_sync = ~adc_sync;
        drain("drain_overrun");
        chk("overrun_set", overrun, 1);
        chk("overrun_sum", dut.sum_q, win_sum());
        for (int i = 0; i < 5; i++) send_rnd_gap(int'($urandom_range(4095, 0)));
        drain("drain_post_overrun");
        chk("overrun_sticky", overrun, 1);

        // Reset asserted while the sequencer sits in CMP
        send(3000, 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_cas_bit", cas_bit, 0);
        chk("midrst_stb", sample_stb, 0);
        chk("midrst_avg", avg, 0);
        chk("midrst_carrier", carrier, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_state", dut.state_q, ST_CLEAR);

        // Recovery after reset
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (520) @(posedge clk);
        for (int i = 0; i < 4; i++) send_rnd_gap(int'($urandom_range(4095, 0)));
        drain("drain_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
